// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// character width and the default bit period for a 50 MHz / 115200 baud link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_BAUD_DEFAULT_CPB = 434;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so an idle-high serial line can be held at its idle level.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] stages;

    // Shift the asynchronous input through the flop chain; oldest stage is the output.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stages <= {STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[STAGES-2:0], i_d};
        end
    end

    assign o_q = stages[STAGES-1];

endmodule

// File: rtl/uart_char_rx.sv
// 8N1 UART character receiver for the NMEA sentence path. Samples each bit at
// mid-bit, publishes good characters with a one-cycle o_finished strobe and
// reports a low stop bit with a one-cycle o_frame_err strobe. After a framing
// error the receiver waits for the line to return high so a held-low break
// never starts a new frame.
module uart_char_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_BAUD_DEFAULT_CPB,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_char,
    output logic       o_finished,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int BCNT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0]  HALF_LAST     = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
    localparam logic [BCNT_W-1:0] BIT_CNT_LAST  = BCNT_W'(UART_DATA_BITS - 1);
    localparam logic [BCNT_W-1:0] BIT_CNT_ONE   = BCNT_W'(1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_BREAK = BREAK;

    logic                      rx_s;
    logic [2:0]                state;
    logic [CNT_W-1:0]          clk_cnt;
    logic [BCNT_W-1:0]         bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;

    // Bring the asynchronous line into the clock domain; flops reset to the idle level.
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // Frame FSM: qualify the start bit at half a bit, sample data and stop at mid-bit, and
    // return to IDLE right after the stop sample so back-to-back frames are not lost.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_char      <= 8'h00;
            o_finished  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_finished  <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                    end
                end
                S_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_CNT_ONE;
                        if (bit_cnt == BIT_CNT_LAST) begin
                            state <= S_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            o_char     <= shreg;
                            o_finished <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (state != S_IDLE);

endmodule
